// File: rtl/day08_pkg.sv
// Shared types for the day-08 pair scheduler: state enum, coordinate
// type and index-width helper.
package day08_pkg;

    localparam int PKG_COORD_WIDTH = 32;

    typedef logic [PKG_COORD_WIDTH-1:0] coord_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } sched_state_e;

    // A one-entry store still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/node_coord_store.sv
// Node coordinate register file: one write port, NUM_READ comb read ports.
// Ports: i_clk, i_wr_en/i_wr_addr/i_wr_data, i_rd_addr -> o_rd_data (0 if out of range).
module node_coord_store
    import day08_pkg::*;
#(
    parameter int MAX_NODE_COUNT  = 10,
    parameter int COORD_BIT_WIDTH = 32,
    parameter int DIMENSIONS      = 3,
    parameter int NUM_READ        = 2,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [ADDR_WIDTH-1:0]      i_wr_addr,
    input  logic [COORD_BIT_WIDTH-1:0] i_wr_data [0:DIMENSIONS-1],
    input  logic [ADDR_WIDTH-1:0]      i_rd_addr [0:NUM_READ-1],
    output logic [COORD_BIT_WIDTH-1:0] o_rd_data [0:NUM_READ-1][0:DIMENSIONS-1]
);

    logic [COORD_BIT_WIDTH-1:0] r_mem [0:MAX_NODE_COUNT-1][0:DIMENSIONS-1];

    always_ff @(posedge i_clk) begin
        for (int s = 0; s < MAX_NODE_COUNT; s++) begin
            if (i_wr_en && i_wr_addr == ADDR_WIDTH'(s)) begin
                for (int d = 0; d < DIMENSIONS; d++) begin
                    r_mem[s][d] <= i_wr_data[d];
                end
            end
        end
    end

    // Slot compare rather than direct indexing so wide addresses read 0.
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            for (int d = 0; d < DIMENSIONS; d++) begin
                o_rd_data[p][d] = '0;
            end
            for (int s = 0; s < MAX_NODE_COUNT; s++) begin
                if (i_rd_addr[p] == ADDR_WIDTH'(s)) begin
                    for (int d = 0; d < DIMENSIONS; d++) begin
                        o_rd_data[p][d] = r_mem[s][d];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pair_batch_scheduler.sv
// Captures node coordinates, then replays them as the upper-triangular pair
// stream (reference in lane 0, higher nodes BATCH_SIZE per beat).
// Ports: load_* (loader handshake), batch_* / out_ready (beat stream),
// busy, done (pulse), overflow (sticky), stall_cycles.
// Optional PAIR_SCHED_STALL_COUNT_EN builds the saturating stall counter.
module pair_batch_scheduler
    import day08_pkg::*;
#(
    parameter int MAX_NODE_COUNT   = 10,
    parameter int COORD_BIT_WIDTH  = PKG_COORD_WIDTH,
    parameter int DIMENSIONS       = 3,
    parameter int BATCH_SIZE       = 2,
    localparam int INDEX_BIT_WIDTH = idx_width(MAX_NODE_COUNT),
    localparam int COUNT_BIT_WIDTH = $clog2(MAX_NODE_COUNT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    input  logic [COORD_BIT_WIDTH-1:0] load_coord [0:DIMENSIONS-1],
    input  logic                       load_last,
    output logic                       load_ready,
    output logic [COORD_BIT_WIDTH-1:0] batch_coords [0:BATCH_SIZE-1][0:DIMENSIONS-1],
    output logic [INDEX_BIT_WIDTH-1:0] batch_indices [0:BATCH_SIZE-1],
    output logic [BATCH_SIZE-1:0]      batch_valid,
    output logic                       batch_line_end,
    output logic                       batch_stream_end,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [31:0]                stall_cycles
);

    localparam int SUM_W = COUNT_BIT_WIDTH + 1;
    typedef logic [SUM_W-1:0] sum_t;

    sched_state_e               r_state, w_state_nx;
    logic [COUNT_BIT_WIDTH-1:0] r_count, w_count_nx;
    sum_t                       r_ref, r_pos, w_ref_nx, w_pos_nx;
    logic w_load_acc, w_full, w_wr_en, w_beat_acc;
    logic w_set_beat, w_clr_beat, w_done_nx;

    sum_t w_n, w_last_ref, w_base;
    sum_t w_rd_addr [0:BATCH_SIZE-1];
    logic [COORD_BIT_WIDTH-1:0] w_rd_data [0:BATCH_SIZE-1][0:DIMENSIONS-1];
    logic [COORD_BIT_WIDTH-1:0] w_lane_coord [0:BATCH_SIZE-1][0:DIMENSIONS-1];
    logic [BATCH_SIZE-1:0] w_lane_vld;
    logic w_line_end, w_stream_end;

    logic [COORD_BIT_WIDTH-1:0] r_coords [0:BATCH_SIZE-1][0:DIMENSIONS-1];
    logic [INDEX_BIT_WIDTH-1:0] r_idx [0:BATCH_SIZE-1];
    logic [BATCH_SIZE-1:0]      r_valid;
    logic r_line_end, r_stream_end;
    logic r_load_ready, r_busy, r_done, r_overflow;

    assign w_load_acc = (r_state == S_IDLE) && r_load_ready && load_valid;
    assign w_full     = (r_count == COUNT_BIT_WIDTH'(MAX_NODE_COUNT));
    assign w_wr_en    = w_load_acc && !w_full;
    assign w_beat_acc = (|r_valid) && out_ready;

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_ref_nx   = r_ref;
        w_pos_nx   = r_pos;
        w_set_beat = 1'b0;
        w_clr_beat = 1'b0;
        w_done_nx  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_wr_en) begin
                    w_count_nx = r_count + COUNT_BIT_WIDTH'(1);
                end
                if (w_load_acc && load_last) begin
                    w_ref_nx = '0;
                    w_pos_nx = '0;
                    if (w_count_nx == '0) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_STREAM;
                        w_set_beat = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (w_beat_acc) begin
                    if (r_stream_end) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                        w_clr_beat = 1'b1;
                    end else if (r_line_end) begin
                        w_ref_nx   = r_ref + sum_t'(1);
                        w_pos_nx   = '0;
                        w_set_beat = 1'b1;
                    end else begin
                        w_pos_nx   = r_pos + sum_t'(BATCH_SIZE);
                        w_set_beat = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_count_nx = '0;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Next beat is built from next-cycle ref/pos so every output is a flop.
    always_comb begin
        w_n        = sum_t'(w_count_nx);
        w_last_ref = (w_n >= sum_t'(2)) ? w_n - sum_t'(2) : '0;
        w_base     = w_ref_nx + w_pos_nx;
        w_line_end = (w_base + sum_t'(BATCH_SIZE)) >= w_n;
        w_stream_end = w_line_end && (w_ref_nx == w_last_ref);
        for (int k = 0; k < BATCH_SIZE; k++) begin
            w_rd_addr[k]  = w_base + sum_t'(k);
            w_lane_vld[k] = w_rd_addr[k] < w_n;
        end
    end

    // The final node is written on the same edge the first beat is
    // captured, so forward it straight from the load port.
    always_comb begin
        for (int k = 0; k < BATCH_SIZE; k++) begin
            for (int d = 0; d < DIMENSIONS; d++) begin
                w_lane_coord[k][d] = w_rd_data[k][d];
                if (w_wr_en && w_rd_addr[k] == sum_t'(r_count)) begin
                    w_lane_coord[k][d] = load_coord[d];
                end
            end
        end
    end

    node_coord_store #(
        .MAX_NODE_COUNT (MAX_NODE_COUNT),
        .COORD_BIT_WIDTH(COORD_BIT_WIDTH),
        .DIMENSIONS     (DIMENSIONS),
        .NUM_READ       (BATCH_SIZE),
        .ADDR_WIDTH     (SUM_W)
    ) u_store (
        .i_clk    (clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(sum_t'(r_count)),
        .i_wr_data(load_coord),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_ref        <= '0;
            r_pos        <= '0;
            r_load_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_valid      <= '0;
            r_line_end   <= 1'b0;
            r_stream_end <= 1'b0;
            for (int k = 0; k < BATCH_SIZE; k++) begin
                r_idx[k] <= '0;
                for (int d = 0; d < DIMENSIONS; d++) begin
                    r_coords[k][d] <= '0;
                end
            end
        end else begin
            r_count      <= w_count_nx;
            r_ref        <= w_ref_nx;
            r_pos        <= w_pos_nx;
            r_load_ready <= (w_state_nx == S_IDLE);
            r_busy       <= (w_state_nx != S_IDLE);
            r_done       <= w_done_nx;
            r_overflow   <= r_overflow | (w_load_acc && w_full);
            if (w_set_beat) begin
                r_valid      <= w_lane_vld;
                r_line_end   <= w_line_end;
                r_stream_end <= w_stream_end;
                for (int k = 0; k < BATCH_SIZE; k++) begin
                    r_idx[k] <= INDEX_BIT_WIDTH'(w_rd_addr[k]);
                    for (int d = 0; d < DIMENSIONS; d++) begin
                        r_coords[k][d] <= w_lane_coord[k][d];
                    end
                end
            end else if (w_clr_beat) begin
                r_valid      <= '0;
                r_line_end   <= 1'b0;
                r_stream_end <= 1'b0;
                for (int k = 0; k < BATCH_SIZE; k++) begin
                    r_idx[k] <= '0;
                    for (int d = 0; d < DIMENSIONS; d++) begin
                        r_coords[k][d] <= '0;
                    end
                end
            end
        end
    end

`ifdef PAIR_SCHED_STALL_COUNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((|r_valid) && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

    assign load_ready       = r_load_ready;
    assign busy             = r_busy;
    assign done             = r_done;
    assign overflow         = r_overflow;
    assign batch_valid      = r_valid;
    assign batch_line_end   = r_line_end;
    assign batch_stream_end = r_stream_end;
    assign batch_indices    = r_idx;
    assign batch_coords     = r_coords;

endmodule

// File: tb/tb_pair_batch_scheduler.sv
// Scoreboard bench for pair_batch_scheduler: default build, a BATCH_SIZE=3
// instance and a MAX_NODE_COUNT=3 instance.
module tb_pair_batch_scheduler;
    import day08_pkg::*;

    localparam int D = 3;

    typedef struct packed {
        logic [2:0]      vld;
        logic            le;
        logic            se;
        logic [2:0][3:0] idx;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    beat_t sb[$];

    // default instance
    logic        load_valid, load_last, load_ready, out_ready;
    logic [31:0] load_coord [0:D-1];
    logic [31:0] batch_coords [0:1][0:D-1];
    logic [3:0]  batch_indices [0:1];
    logic [1:0]  batch_valid;
    logic        batch_line_end, batch_stream_end;
    logic        busy, done, overflow;
    logic [31:0] stall_cycles;

    // BATCH_SIZE=3 instance
    logic        b3_lv, b3_ll, b3_lr, b3_or;
    logic [31:0] b3_lc [0:D-1];
    logic [31:0] b3_crd [0:2][0:D-1];
    logic [3:0]  b3_idx [0:2];
    logic [2:0]  b3_vld;
    logic        b3_le, b3_se, b3_busy, b3_done, b3_ovf;
    logic [31:0] b3_stall;

    // MAX_NODE_COUNT=3 instance
    logic        m3_lv, m3_ll, m3_lr, m3_or;
    logic [31:0] m3_lc [0:D-1];
    logic [31:0] m3_crd [0:1][0:D-1];
    logic [1:0]  m3_idx [0:1];
    logic [1:0]  m3_vld;
    logic        m3_le, m3_se, m3_busy, m3_done, m3_ovf;
    logic [31:0] m3_stall;

    pair_batch_scheduler u_dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_coord(load_coord),
        .load_last(load_last), .load_ready(load_ready),
        .batch_coords(batch_coords), .batch_indices(batch_indices),
        .batch_valid(batch_valid), .batch_line_end(batch_line_end),
        .batch_stream_end(batch_stream_end), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow),
        .stall_cycles(stall_cycles)
    );

    pair_batch_scheduler #(.BATCH_SIZE(3)) u_b3 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(b3_lv), .load_coord(b3_lc),
        .load_last(b3_ll), .load_ready(b3_lr),
        .batch_coords(b3_crd), .batch_indices(b3_idx),
        .batch_valid(b3_vld), .batch_line_end(b3_le),
        .batch_stream_end(b3_se), .out_ready(b3_or),
        .busy(b3_busy), .done(b3_done), .overflow(b3_ovf),
        .stall_cycles(b3_stall)
    );

    pair_batch_scheduler #(.MAX_NODE_COUNT(3)) u_m3 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(m3_lv), .load_coord(m3_lc),
        .load_last(m3_ll), .load_ready(m3_lr),
        .batch_coords(m3_crd), .batch_indices(m3_idx),
        .batch_valid(m3_vld), .batch_line_end(m3_le),
        .batch_stream_end(m3_se), .out_ready(m3_or),
        .busy(m3_busy), .done(m3_done), .overflow(m3_ovf),
        .stall_cycles(m3_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic coord_t coord_of(input int salt, input int i,
                                        input int d);
        return coord_t'(salt * 4096 + i * 16 + d + 1);
    endfunction

    // Reference pair-stream generator: one entry per expected beat.
    task automatic push_stream(input int n, input int b);
        int last_ref;
        int p;
        bit le;
        beat_t e;
        last_ref = (n >= 2) ? n - 2 : 0;
        for (int r = 0; r <= last_ref; r++) begin
            p = 0;
            le = 0;
            while (!le) begin
                e = '0;
                for (int k = 0; k < b; k++) begin
                    e.idx[k] = 4'(r + p + k);
                    e.vld[k] = (r + p + k) < n;
                end
                le = (r + p + b) >= n;
                e.le = le;
                e.se = le && (r == last_ref);
                sb.push_back(e);
                p += b;
            end
        end
    endtask

    task automatic chk_main_beat(input beat_t e, input int salt);
        chk("m_vld", batch_valid, e.vld[1:0]);
        chk("m_le", batch_line_end, e.le);
        chk("m_se", batch_stream_end, e.se);
        for (int k = 0; k < 2; k++) begin
            if (e.vld[k]) begin
                chk("m_idx", batch_indices[k], e.idx[k]);
                for (int d = 0; d < D; d++) begin
                    chk("m_crd", batch_coords[k][d],
                        coord_of(salt, int'(e.idx[k]), d));
                end
            end
        end
    endtask

    task automatic load_main(input int n, input int salt);
        int c;
        c = 0;
        while (!load_ready && c < 20) begin
            step();
            c++;
        end
        chk("m_ld_rdy", load_ready, 1);
        push_stream(n, 2);
        for (int i = 0; i < n; i++) begin
            load_valid = 1;
            load_last = (i == n - 1);
            for (int d = 0; d < D; d++) load_coord[d] = coord_of(salt, i, d);
            step();
        end
        load_valid = 0;
        load_last = 0;
        chk("m_first_beat", |batch_valid, 1);
        chk("m_busy", busy, 1);
    endtask

    // pat 1: out_ready 1,0,0,1 on the first valid cycles, then high.
    task automatic run_main(input int pat, input int salt, output int nacc);
        int c;
        int vc;
        c = 0;
        vc = 0;
        nacc = 0;
        while (sb.size() > 0 && c < 200) begin
            if (|batch_valid) begin
                chk_main_beat(sb[0], salt);
                out_ready = !(pat == 1 && (vc == 1 || vc == 2));
                vc++;
                if (out_ready) begin
                    void'(sb.pop_front());
                    nacc++;
                end
            end
            step();
            c++;
        end
        out_ready = 1;
        chk("m_sb_drain", sb.size(), 0);
    endtask

    task automatic finish_main();
        chk("m_done", done, 1);
        chk("m_vld_clr", batch_valid, 0);
        chk("m_se_clr", batch_stream_end, 0);
        step();
        chk("m_done_pulse", done, 0);
        chk("m_ld_rdy_back", load_ready, 1);
        chk("m_idle", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacc;
        int c;
        rst_n = 0;
        load_valid = 0; load_last = 0; out_ready = 1;
        b3_lv = 0; b3_ll = 0; b3_or = 1;
        m3_lv = 0; m3_ll = 0; m3_or = 1;
        for (int d = 0; d < D; d++) begin
            load_coord[d] = '0;
            b3_lc[d] = '0;
            m3_lc[d] = '0;
        end
        step();
        step();
        chk("rst_ld_rdy", load_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vld", batch_valid, 0);
        chk("rst_le", batch_line_end, 0);
        chk("rst_se", batch_stream_end, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_stall", stall_cycles, 0);
        rst_n = 1;
        step();
        chk("ld_rdy_rise", load_ready, 1);

        // N=4, out_ready high
        load_main(4, 1);
        run_main(0, 1, nacc);
        chk("n4_beats", nacc, 5);
        finish_main();

        // N=4 with stalls
        load_main(4, 2);
        run_main(1, 2, nacc);
        chk("n4s_beats", nacc, 5);
        finish_main();
`ifdef PAIR_SCHED_STALL_COUNT_EN
        chk("stall_cnt", stall_cycles, 2);
`else
        chk("stall_cnt", stall_cycles, 0);
`endif

        // N=1
        load_main(1, 5);
        run_main(0, 5, nacc);
        chk("n1_beats", nacc, 1);
        finish_main();
        chk("m_ovf_clear", overflow, 0);

        // N=2 at BATCH_SIZE=3
        push_stream(2, 3);
        for (int i = 0; i < 2; i++) begin
            b3_lv = 1;
            b3_ll = (i == 1);
            for (int d = 0; d < D; d++) b3_lc[d] = coord_of(9, i, d);
            step();
        end
        b3_lv = 0;
        b3_ll = 0;
        chk("b3_vld", b3_vld, sb[0].vld);
        chk("b3_le", b3_le, sb[0].le);
        chk("b3_se", b3_se, sb[0].se);
        chk("b3_idx0", b3_idx[0], sb[0].idx[0]);
        chk("b3_idx1", b3_idx[1], sb[0].idx[1]);
        chk("b3_crd", b3_crd[1][2], coord_of(9, 1, 2));
        void'(sb.pop_front());
        step();
        chk("b3_done", b3_done, 1);
        chk("b3_sb", sb.size(), 0);

        // MAX=3, four loads: last one overflows
        push_stream(3, 2);
        for (int i = 0; i < 4; i++) begin
            m3_lv = 1;
            m3_ll = (i == 3);
            for (int d = 0; d < D; d++) m3_lc[d] = coord_of(7, i, d);
            step();
        end
        m3_lv = 0;
        m3_ll = 0;
        chk("m3_ovf", m3_ovf, 1);
        nacc = 0;
        c = 0;
        while (sb.size() > 0 && c < 20) begin
            if (|m3_vld) begin
                chk("m3_vld", m3_vld, sb[0].vld[1:0]);
                chk("m3_le", m3_le, sb[0].le);
                chk("m3_se", m3_se, sb[0].se);
                for (int k = 0; k < 2; k++) begin
                    if (sb[0].vld[k]) begin
                        chk("m3_idx", m3_idx[k], sb[0].idx[k]);
                        chk("m3_crd", m3_crd[k][0],
                            coord_of(7, int'(sb[0].idx[k]), 0));
                    end
                end
                void'(sb.pop_front());
                nacc++;
            end
            step();
            c++;
        end
        chk("m3_beats", nacc, 3);
        chk("m3_done", m3_done, 1);
        step();
        chk("m3_ovf_sticky", m3_ovf, 1);

        // Reset during the third beat, then a fresh N=3 stream
        load_main(4, 3);
        for (int j = 0; j < 2; j++) begin
            chk_main_beat(sb[0], 3);
            void'(sb.pop_front());
            step();
        end
        chk("r_beat3", |batch_valid, 1);
        rst_n = 0;
        #1;
        chk("r_vld", batch_valid, 0);
        chk("r_le", batch_line_end, 0);
        chk("r_se", batch_stream_end, 0);
        chk("r_busy", busy, 0);
        chk("r_ld_rdy", load_ready, 0);
        chk("r_idx", batch_indices[0], 0);
        chk("r_crd", batch_coords[0][0], 0);
        chk("r_stall", stall_cycles, 0);
        sb.delete();
        step();
        rst_n = 1;
        step();
        chk("r_ld_rdy_rise", load_ready, 1);
        load_main(3, 4);
        run_main(0, 4, nacc);
        chk("n3_beats", nacc, 3);
        finish_main();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
